// File: rtl/scan_decoder_pkg.sv
// Shared encodings for the scan_decoder slice: control-input meanings for
// the mode and scan-direction pins.
package scan_decoder_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam logic DIR_UP      = 1'b0;
  localparam logic DIR_DOWN    = 1'b1;

endpackage

// File: rtl/onehot_dec.sv
// Combinational N-to-2^N one-hot decoder with enable and selectable polarity.
// y[0] corresponds to sel == 0.
module onehot_dec #(
  parameter int N          = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic             en,
  input  logic [N-1:0]     sel,
  output logic [0:2**N-1]  y
);

  always_comb begin
    y = '0;
    if (en) y[sel] = 1'b1;
    if (ACTIVE_LOW) y = ~y;
  end

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with direct-select and autonomous scan modes;
// scan mode holds each index for DWELL cycles before stepping.
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int N          = 4,
  parameter int DWELL      = 1,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [N-1:0]     d,
  output logic [0:2**N-1]  y,
  output logic [N-1:0]     idx,
  output logic             wrap
);

  localparam int                CW     = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0]     TC     = CW'(DWELL - 1);
  localparam logic [0:2**N-1]   Y_IDLE = {(2**N){ACTIVE_LOW}};

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N-1:0]     idx_d;
  logic             wrap_d;
  logic [0:2**N-1]  y_d;

  // Next index is computed first and decoded directly, so y always shows
  // the index that idx will hold after the same edge.
  always_comb begin
    idx_d  = idx;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (mode == MODE_DIRECT) begin
      idx_d = d;
      cnt_d = '0;
    end else if (load) begin
      idx_d = d;
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == TC) begin
        cnt_d = '0;
        if (dir == DIR_DOWN) begin
          idx_d  = idx - N'(1);
          wrap_d = (idx == '0);
        end else begin
          idx_d  = idx + N'(1);
          wrap_d = (idx == '1);
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  onehot_dec #(
    .N          (N),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_dec (
    .en  (en),
    .sel (idx_d),
    .y   (y_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      cnt_q <= '0;
      wrap  <= 1'b0;
      y     <= Y_IDLE;
    end else begin
      idx   <= idx_d;
      cnt_q <= cnt_d;
      wrap  <= wrap_d;
      y     <= y_d;
    end
  end

endmodule

// File: tb/tb_scan_decoder.sv
// Scoreboard bench: stimulus queues hand-computed expectations per edge, a
// monitor pops and compares one entry after every rising edge.
module tb_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en = 1'b0, mode = 1'b0, dir = 1'b0, load = 1'b0;
  logic [3:0]  d = '0;
  logic [0:15] y, y_al;
  logic [3:0]  idx, idx_al;
  logic        wrap, wrap_al;

  typedef struct {
    int          ph;
    logic [3:0]  idx;
    logic [15:0] y;
    logic        wrap;
    logic [3:0]  idx_al;
    logic [15:0] y_al;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  scan_decoder #(.N(4), .DWELL(3), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .dir(dir), .load(load),
    .d(d), .y(y), .idx(idx), .wrap(wrap)
  );

  scan_decoder #(.N(4), .DWELL(1), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .dir(dir), .load(load),
    .d(d), .y(y_al), .idx(idx_al), .wrap(wrap_al)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pk(input logic [0:15] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[i];
    return r;
  endfunction

  function automatic logic [15:0] oh(input int i);
    logic [15:0] r;
    logic [3:0]  s;
    s = i[3:0];
    r = '0;
    r[s] = 1'b1;
    return r;
  endfunction

  function automatic exp_t ex(input int ph, input int i, input logic [15:0] yv,
                              input logic w, input int ia, input logic [15:0] ya);
    exp_t e;
    e.ph = ph; e.idx = i[3:0]; e.y = yv; e.wrap = w;
    e.idx_al = ia[3:0]; e.y_al = ya;
    return e;
  endfunction

  task automatic cmp(input int ph, input string nm, input logic [15:0] got,
                     input logic [15:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL ph%0d %s: got %h expected %h", ph, nm, got, req);
    end
  endtask

  task automatic step(input logic e_i, input logic m_i, input logic dr_i,
                      input logic l_i, input logic [3:0] d_i, input exp_t x);
    @(negedge clk);
    en = e_i; mode = m_i; dir = dr_i; load = l_i; d = d_i;
    sb.push_back(x);
  endtask

  task automatic check_now(input int ph);
    cmp(ph, "async_idx",    {12'b0, idx},    16'h0000);
    cmp(ph, "async_y",      pk(y),           16'h0000);
    cmp(ph, "async_wrap",   {15'b0, wrap},   16'h0000);
    cmp(ph, "async_idx_al", {12'b0, idx_al}, 16'h0000);
    cmp(ph, "async_y_al",   pk(y_al),        16'hFFFF);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      cmp(e.ph, "idx",    {12'b0, idx},    {12'b0, e.idx});
      cmp(e.ph, "y",      pk(y),           e.y);
      cmp(e.ph, "wrap",   {15'b0, wrap},   {15'b0, e.wrap});
      cmp(e.ph, "idx_al", {12'b0, idx_al}, {12'b0, e.idx_al});
      cmp(e.ph, "y_al",   pk(y_al),        e.y_al);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int i, ia;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_now(0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // direct decode sweep, then blank
    for (int k = 0; k < 16; k++)
      step(1, 0, 0, 0, 4'(k), ex(1, k, oh(k), 0, k, ~oh(k)));
    step(0, 0, 0, 0, 4'd15, ex(1, 15, 16'h0000, 0, 15, 16'hFFFF));

    // scan up from 0, dwell 3 (AL instance steps every edge)
    step(1, 0, 0, 0, 4'd0, ex(2, 0, oh(0), 0, 0, ~oh(0)));
    for (int n = 1; n <= 50; n++) begin
      i  = (n / 3) % 16;
      ia = n % 16;
      step(1, 1, 0, 0, 4'd0, ex(2, i, oh(i), n == 48, ia, ~oh(ia)));
    end

    // scan down after load 2; wrap on 0 -> 15; load on terminal edge
    step(1, 1, 1, 1, 4'd2, ex(3, 2, oh(2), 0, 2, ~oh(2)));
    for (int m = 1; m <= 11; m++) begin
      i  = (2 - m / 3) & 15;
      ia = (2 - m) & 15;
      step(1, 1, 1, 0, 4'd0, ex(3, i, oh(i), m == 9, ia, ~oh(ia)));
    end
    step(1, 1, 1, 1, 4'd7, ex(3, 7, oh(7), 0, 7, ~oh(7)));

    // pause mid-dwell for 5 cycles, then finish remaining dwell
    step(1, 1, 0, 0, 4'd7, ex(4, 7, oh(7), 0, 8, ~oh(8)));
    repeat (5) step(0, 1, 0, 0, 4'd7, ex(4, 7, 16'h0000, 0, 8, 16'hFFFF));
    step(1, 1, 0, 0, 4'd7, ex(4, 7, oh(7), 0, 9, ~oh(9)));
    step(1, 1, 0, 0, 4'd7, ex(4, 8, oh(8), 0, 10, ~oh(10)));

    // reach idx 9 mid-dwell, then pulse reset between edges
    step(1, 1, 0, 0, 4'd7, ex(6, 8, oh(8), 0, 11, ~oh(11)));
    step(1, 1, 0, 0, 4'd7, ex(6, 8, oh(8), 0, 12, ~oh(12)));
    step(1, 1, 0, 0, 4'd7, ex(6, 9, oh(9), 0, 13, ~oh(13)));
    step(1, 1, 0, 0, 4'd7, ex(6, 9, oh(9), 0, 14, ~oh(14)));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_now(6);
    #1 rst_n = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      i = n / 3;
      step(1, 1, 0, 0, 4'd7, ex(6, i, oh(i), 0, n, ~oh(n)));
    end

    // back to direct; load ignored there
    step(1, 0, 0, 1, 4'd12, ex(7, 12, oh(12), 0, 12, ~oh(12)));

    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/scan_decoder.md
# scan_decoder

Parametrised, registered N-to-2^N one-hot decoder with enable, a direct-select mode and an autonomous scan mode. Scan mode steps the active output through all 2^N positions, holding each position for a programmable dwell time. The block drives LED-matrix column strobes, keypad row scans and 7-segment digit multiplexing in the lab designs. It is the clocked, generalised successor to the fixed 4-to-16 enable decoder.

## Interface
- `N`, 4: select width; the output width is `2**N`.
- `DWELL`, 1: clock cycles each index is held in scan mode; must be ≥ 1.
- `ACTIVE_LOW`, 0: 1 inverts `y`, so the selected line is 0 and the idle lines are 1.
- `clk` input, 1 bit: the single clock; all state changes on its rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `en` input, 1 bit: output enable and scan run.
- `mode` input, 1 bit: 0 = direct, 1 = scan.
- `dir` input, 1 bit: scan direction; 0 = up (+1), 1 = down (−1).
- `load` input, 1 bit: in scan mode, loads `d` as the scan index.
- `d` input, N bits: direct select, or scan start index.
- `y` output, [0:2**N-1]: one-hot (or one-cold) registered output; `y[0]` corresponds to index 0.
- `idx` output, N bits: index currently driven on `y`.
- `wrap` output, 1 bit: one-cycle pulse when the scan index wraps.

## Operation
- **Reset (`rst_n` = 0, asynchronous):**
  - `idx` = 0 and the dwell counter = 0.
  - `wrap` = 0.
  - `y` is all inactive: all 0, or all 1 when `ACTIVE_LOW` = 1.
- **Inactive output:** whenever `en` = 0, `y` is all-inactive on the next edge.
- **Direct mode (`mode` = 0):**
  - Each edge: `idx` ← `d`; `y` ← onehot(`d`) if `en` = 1, else all-inactive.
  - The dwell counter is held at 0. `wrap` = 0.
- **Scan mode (`mode` = 1, `en` = 1):**
  - The dwell counter counts 0 … `DWELL`−1.
  - At terminal count the counter returns to 0 and `idx` ← `idx` ± 1 mod 2^N, per `dir`.
  - `y` is registered from the new `idx`.
- **Scan mode (`mode` = 1, `en` = 0):** `idx` and the dwell counter hold; `y` is inactive.
- **`wrap`:**
  - Asserted for exactly the edge on which `idx` advances 2^N−1 → 0 (up) or 0 → 2^N−1 (down).
  - Never asserted by `load` or in direct mode.
- **`load` (scan mode only):**
  - `idx` ← `d` and the dwell counter ← 0.
  - Has priority over a simultaneous advance; `wrap` = 0 on that edge.
  - Acts even when `en` = 0, so the scan start can be preset while blanked.
  - Ignored in direct mode.
- **Mode switches:**
  - Scan → direct: `d` takes effect on the next edge.
  - Direct → scan: scanning starts from the current `idx` with the dwell counter at 0. The first advance occurs `DWELL` cycles after the switch edge.
- **`dir` change mid-dwell:** affects only the next advance; the dwell counter is not reset.
- **`DWELL` = 1:** `idx` advances on every enabled edge.

## Timing
- Latency from `d`/`en` to `y` is 1 clock in direct mode.
- `y`, `idx` and `wrap` are all registered, so there are no combinational input-to-output paths.
- In scan mode, `y` changes one edge after the dwell counter reaches `DWELL`−1. The full cycle period is 2^N × `DWELL` clocks.
- `wrap` goes high in the same cycle that `y` first shows the wrapped index.
- Reset released mid-scan restarts from `idx` 0 with a full dwell.
- Reset asserted mid-dwell clears the outputs immediately, without waiting for a clock edge.

## Structure
- Shared package/header `scan_decoder_pkg` holds:
  - the mode encodings `MODE_DIRECT` = 0 and `MODE_SCAN` = 1;
  - the direction encodings `DIR_UP` = 0 and `DIR_DOWN` = 1.
- Sub-module `onehot_dec`: a purely combinational, N-parametrised one-hot decoder with its own enable input and polarity parameter.
- The top level contains:
  - the index register;
  - the dwell counter, width clog2(`DWELL`) with a minimum of 1 bit;
  - the wrap flag;
  - the output register fed by `onehot_dec`.

## Test plan
1. **Reset and direct decode** (`N` = 4): `rst_n` = 0 → `y` = 0, `idx` = 0, `wrap` = 0. Release reset, `mode` = 0, `en` = 1, sweep `d` = 0…15 → one edge later each time, `y[d]` is the only 1. `en` = 0 with `d` = 15 → `y` = 0.
2. **Scan up with dwell** (`DWELL` = 3): `mode` = 1, `en` = 1, `dir` = 0 from `idx` 0 → `idx` steps 0, 1, 2…, each held 3 cycles. On the 15 → 0 step, `wrap` = 1 for exactly one cycle, 48 cycles after the scan started.
3. **Scan down with load:** `load` = 1, `d` = 2, `dir` = 1 → `idx` = 2, then 1, then 0, then 15 with the `wrap` pulse. A `load` issued on a terminal-count edge gives `idx` = `d` and no `wrap`.
4. **Pause:** in scan mode, drop `en` for 5 cycles mid-dwell → `y` = 0 and `idx` frozen. On re-enable, the remaining dwell completes before the next advance.
5. **`ACTIVE_LOW` = 1:** after reset `y` = 16'hFFFF; direct `d` = 5 → only `y[5]` = 0.
6. **Asynchronous reset mid-scan:** pulse `rst_n` low between edges at `idx` = 9 → outputs clear immediately. After release, scanning resumes from 0 with a full 3-cycle dwell.
